// File: rtl/cd_host_regs.sv
// CD-block host register window (A-bus CS2, AA[25:16]=0x189): HIRQ, HIRQMASK,
// CR1-CR4, plus the command/response handshake with the CD back-end.
module cd_host_regs (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [25:0] AA,
  input  logic [15:0] ADI,
  output logic [15:0] ADO,
  input  logic        ACS2_N,
  input  logic        ARD_N,
  input  logic        AWRU_N,
  input  logic        AWRL_N,
  output logic        AWAIT_N,
  output logic        AIRQ_N,
  output logic        CMD_VALID,
  output logic [63:0] CMD,
  input  logic        CMD_ACK,
  input  logic        RSP_VALID,
  input  logic [63:0] RSP,
  input  logic [15:0] HIRQ_SET
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RSP} state_t;

  state_t      state_q, state_d;
  logic [15:0] hirq_q, hirq_d, mask_q;
  logic [15:0] cmd_cr_q [4];
  logic [15:0] rsp_cr_q [4];
  logic        ard_q, awru_q, awrl_q;

  logic        hit, rd_start, wu_start, wl_start, wr_start;
  logic        sel_hirq, sel_mask, cr_hit;
  logic [1:0]  cr_idx;
  logic [15:0] rd_data;
  logic        cr_wr_ok, cmd_issue, cmok_set;
  logic        unused_aa0;

  assign unused_aa0 = AA[0];

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic up, input logic lo);
    return {up ? new_v[15:8] : old_v[15:8], lo ? new_v[7:0] : old_v[7:0]};
  endfunction

  // An access starts only on the falling edge of a strobe, as seen on CE_R cycles.
  assign hit      = !ACS2_N && (AA[25:16] == 10'h189);
  assign rd_start = hit && !ARD_N  && ard_q;
  assign wu_start = hit && !AWRU_N && awru_q;
  assign wl_start = hit && !AWRL_N && awrl_q;
  assign wr_start = wu_start || wl_start;

  assign sel_hirq = (AA[15:1] == 15'h0004);
  assign sel_mask = (AA[15:1] == 15'h0006);

  always_comb begin
    cr_hit = 1'b0;
    cr_idx = '0;
    case (AA[15:1])
      15'h000C: begin cr_hit = 1'b1; cr_idx = 2'd0; end
      15'h000E: begin cr_hit = 1'b1; cr_idx = 2'd1; end
      15'h0010: begin cr_hit = 1'b1; cr_idx = 2'd2; end
      15'h0012: begin cr_hit = 1'b1; cr_idx = 2'd3; end
      default:  ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (sel_hirq)      rd_data = hirq_q;
    else if (sel_mask) rd_data = mask_q;
    else if (cr_hit)   rd_data = rsp_cr_q[cr_idx];
  end

  assign cr_wr_ok  = wr_start && cr_hit && (state_q == ST_IDLE);
  assign cmd_issue = cr_wr_ok && (cr_idx == 2'd3);
  assign cmok_set  = (state_q == ST_WAIT_RSP) && RSP_VALID;

  // Priority: host clear, then CMOK clear/set, then back-end set requests win.
  always_comb begin
    hirq_d = hirq_q;
    if (wr_start && sel_hirq)
      hirq_d = lane_merge(hirq_q, hirq_q & ADI, wu_start, wl_start);
    if (cmd_issue) hirq_d[0] = 1'b0;
    if (cmok_set)  hirq_d[0] = 1'b1;
    hirq_d = hirq_d | HIRQ_SET;
  end

  always_comb begin
    state_d   = state_q;
    CMD_VALID = 1'b0;
    case (state_q)
      ST_IDLE:     if (cmd_issue) state_d = ST_ISSUE;
      ST_ISSUE: begin
        CMD_VALID = 1'b1;
        if (CMD_ACK) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: if (RSP_VALID) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       state_q <= ST_IDLE;
    else if (CE_R) state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ard_q       <= 1'b1;
      awru_q      <= 1'b1;
      awrl_q      <= 1'b1;
      hirq_q      <= '1;
      mask_q      <= '1;
      ADO         <= '0;
      AIRQ_N      <= 1'b0;
      rsp_cr_q[0] <= 16'h0043;
      rsp_cr_q[1] <= 16'h4442;
      rsp_cr_q[2] <= 16'h4C4F;
      rsp_cr_q[3] <= 16'h434B;
      for (int unsigned i = 0; i < 4; i++) cmd_cr_q[i] <= '0;
    end else if (CE_R) begin
      ard_q  <= ARD_N;
      awru_q <= AWRU_N;
      awrl_q <= AWRL_N;
      hirq_q <= hirq_d;
      AIRQ_N <= ~|(hirq_q & mask_q);
      if (rd_start) ADO <= rd_data;
      if (wr_start && sel_mask)
        mask_q <= lane_merge(mask_q, ADI, wu_start, wl_start);
      if (cr_wr_ok)
        cmd_cr_q[cr_idx] <= lane_merge(cmd_cr_q[cr_idx], ADI, wu_start, wl_start);
      if (RSP_VALID) begin
        rsp_cr_q[0] <= RSP[63:48];
        rsp_cr_q[1] <= RSP[47:32];
        rsp_cr_q[2] <= RSP[31:16];
        rsp_cr_q[3] <= RSP[15:0];
      end
    end
  end

  assign AWAIT_N = !(CE_R && !RST && (rd_start || wr_start));
  assign CMD     = {cmd_cr_q[0], cmd_cr_q[1], cmd_cr_q[2], cmd_cr_q[3]};

endmodule

// File: doc/cd_host_regs.md
# cd_host_regs

A-bus responder for the CD-block host register window at A-bus CS2, region AA[25:16] = 0x189. It answers SCU A-bus reads and writes to HIRQ, HIRQMASK and CR1–CR4. It forwards each completed 64-bit host command to a CD back-end and presents the back-end's 64-bit response in CR1–CR4. It drives the A-bus interrupt from HIRQ & HIRQMASK, and replaces the fixed-value CD read stub in the top level.

## Interface
- No parameters.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- CE_R  in  1  bus-phase clock enable. All A-bus sampling and register updates happen only on CLK edges with CE_R=1.
- AA  in  26  A-bus address. Bit 0 is ignored.
- ADI  in  16  write data from the SCU (SCU ADO).
- ADO  out  16  read data to the SCU (SCU ADI), registered.
- ACS2_N  in  1  A-bus chip select 2, active low.
- ARD_N  in  1  read strobe, active low.
- AWRU_N  in  1  upper-byte write strobe [15:8], active low.
- AWRL_N  in  1  lower-byte write strobe [7:0], active low.
- AWAIT_N  out  1  wait request to the SCU, active low.
- AIRQ_N  out  1  interrupt to the SCU, active low.
- CMD_VALID  out  1  command available to the back-end.
- CMD  out  64  {CR1,CR2,CR3,CR4} command words.
- CMD_ACK  in  1  back-end accepts the command.
- RSP_VALID  in  1  one-cycle response strobe from the back-end.
- RSP  in  64  {CR1,CR2,CR3,CR4} response words.
- HIRQ_SET  in  16  back-end HIRQ bit set requests, one-cycle pulses.

## Operation
- **Decode.**
  - Hit = !ACS2_N && AA[25:16]==0x189.
  - Offsets ({AA[15:1],0}): 0x08 HIRQ, 0x0C HIRQMASK, 0x18 CR1, 0x1C CR2, 0x20 CR3, 0x24 CR4.
  - Any other offset reads 0x0000, and writes to it are dropped.
- **Access start.** An access starts on the first CE_R cycle where hit=1 and a strobe is low, and the same strobe was high on the previous CE_R cycle. Each strobe assertion performs exactly one register action.
- **Reads.**
  - HIRQ and HIRQMASK return their current values.
  - CR1–CR4 return the response registers RSP_CR1..4, not the command registers.
- **HIRQ write.** HIRQ <= HIRQ & ADI, per enabled byte lane. Writing 0 clears a bit; writing 1 keeps it.
- **HIRQMASK write.** Plain byte-lane write.
- **CR1–CR3 writes.** Byte-lane write into command registers CMD_CR1..3.
- **CR4 write.** Writes CMD_CR4, then issues the command:
  - clears HIRQ bit 0 (CMOK);
  - enters state ISSUE.
- **FSM.**
  - IDLE: a CR4 write moves to ISSUE.
  - ISSUE: CMD_VALID=1 and CMD = {CMD_CR1..4}. On CMD_ACK=1, move to WAIT_RSP.
  - WAIT_RSP: on RSP_VALID=1, move to IDLE and set HIRQ bit 0.
- **Command lock.** While in ISSUE or WAIT_RSP, writes to CR1–CR4 are dropped, so the CMD_CR registers are frozen.
- **Responses.**
  - RSP_VALID in any state loads RSP_CR1..4 from RSP: CR1=RSP[63:48], CR2=RSP[47:32], CR3=RSP[31:16], CR4=RSP[15:0].
  - In IDLE or ISSUE, a response only loads the registers. It is a periodic status report and does not set CMOK.
- **HIRQ_SET.** HIRQ |= HIRQ_SET each cycle, gated by CE_R.
- **Simultaneous events.**
  - A HIRQ_SET bit wins over a host clear of the same bit in the same cycle.
  - A CMOK set from RSP_VALID wins over a host clear of bit 0.
- **Interrupt.** AIRQ_N = ~|(HIRQ & HIRQMASK), registered.

## Timing
- **Reset values.**
  - ADO=0x0000, AWAIT_N=1, AIRQ_N=0 (HIRQ & HIRQMASK is nonzero at reset), CMD_VALID=0, CMD=0.
  - HIRQ=0xFFFF, HIRQMASK=0xFFFF.
  - RSP_CR1..4 = 0x0043, 0x4442, 0x4C4F, 0x434B ("CDBLOCK").
  - CMD_CR1..4 = 0. FSM = IDLE.
- **Read latency.** ADO is valid on the CE_R cycle after the access start. AWAIT_N is 0 for exactly the access-start CE_R cycle, then returns to 1.
- **Write latency.** Writes update the register at the access-start CE_R edge. The new value is readable on the next access.
- **Command handshake.**
  - CMD_VALID rises on the CE_R edge that commits the CR4 write.
  - CMD_VALID stays high until the edge where CMD_ACK=1 is sampled, and is 0 on the following cycle.
  - CMD is stable throughout.
- **Interrupt latency.** AIRQ_N updates one CE_R cycle after any HIRQ or HIRQMASK change.
- **Reset mid-operation.** RST asserted in ISSUE or WAIT_RSP returns all state to its reset value immediately. CMD_VALID drops asynchronously.
- **Clock enable.** With CE_R=0 the block holds all state, and strobes are not sampled.

## Test plan
- **Reset.** Reset, then read 0x18/0x1C/0x20/0x24 -> 0x0043, 0x4442, 0x4C4F, 0x434B. Read 0x08 -> 0xFFFF. AIRQ_N=0.
- **HIRQ/mask/interrupt.**
  - Write HIRQMASK=0x0000 -> AIRQ_N=1.
  - Write HIRQ=0xFFFE, then HIRQMASK=0x0001 -> HIRQ reads 0xFFFE, AIRQ_N=1.
  - Pulse HIRQ_SET=0x0001 -> AIRQ_N=0 one CE_R cycle later.
- **Command round trip.**
  - Write CR1..CR4 = 0x0100, 0x0000, 0x0000, 0x0000 -> CMD_VALID=1, CMD=0x0100_0000_0000_0000, HIRQ bit 0 clear.
  - CMD_ACK -> CMD_VALID=0.
  - RSP_VALID with RSP=0x0012_3456_789A_BCDE -> CR reads return those words, HIRQ bit 0 set.
- **Lock while busy.** In WAIT_RSP, write CR1=0xAAAA and CR4=0x5555 -> no new CMD_VALID. After the response, CMD still shows the old value.
- **Collisions and byte lanes.**
  - Host writes HIRQ=0x0000 in the same cycle HIRQ_SET=0x0010 -> HIRQ=0x0010.
  - Upper-byte-only write 0x12xx to HIRQMASK=0xFFFF -> 0x12FF.
- **Strobes and reset.**
  - Hold ARD_N low for 4 CE_R cycles -> exactly one AWAIT_N low pulse.
  - A read at offset 0x30 returns 0x0000.
  - Assert RST while CMD_VALID=1 -> CMD_VALID=0 immediately, and all reset values are restored.
